pkt_dec: RTL and testbench
==========================

Name: pkt_dec

Overview:
- Receive-side counterpart of the draw-point packet encoder.
- Consumes the byte stream arriving from the link and reassembles 3-byte draw frames into (x, y, color) points.
- Points are presented to the canvas writer over a valid/ready handshake.
- Malformed, out-of-range and stalled frames are rejected and reported.

Parameters:
- X_MAX, 320, first illegal x coordinate (x must be < X_MAX)
- Y_MAX, 240, first illegal y coordinate (y must be < Y_MAX)
- TIMEOUT_CYCLES, 1024, max idle cycles between bytes of one frame; 0 disables timeout

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- pkt_in  input  8  incoming packet byte
- pkt_valid_in  input  1  pkt_in holds a byte this cycle
- pkt_ready_out  output  1  decoder accepts a byte this cycle
- x_out  output  9  decoded x coordinate
- y_out  output  8  decoded y coordinate
- color_out  output  3  decoded color index
- draw_valid_out  output  1  decoded point available
- draw_ready_in  input  1  consumer takes point this cycle
- err_out  output  1  one-cycle pulse on any frame rejection
- err_code_out  output  2  code of most recent rejection (01 header, 10 range, 11 timeout)
- err_count_out  output  8  saturating rejection counter

Behaviour:
Frame format, byte order on the link:
- byte0 header = {x[8], color[2:0], 4'b0000}
- byte1 = x[7:0]
- byte2 = y[7:0]
- A byte is accepted on a cycle with pkt_valid_in && pkt_ready_out.

State machine: HDR, XLO, YB, HOLD.
- HDR: pkt_ready_out=1. On an accepted byte:
  - If low nibble == 0: latch x[8] and color, go to XLO.
  - Otherwise: discard the byte, pulse err_out with code 01, stay in HDR.
- XLO: pkt_ready_out=1. An accepted byte latches x[7:0]; go to YB.
- YB: pkt_ready_out=1. On an accepted byte, compare the assembled x against X_MAX and the byte against Y_MAX.
  - If x >= X_MAX or y >= Y_MAX: drop the frame, pulse err_out with code 10, go to HDR.
  - Otherwise: load x_out/y_out/color_out, assert draw_valid_out on the next cycle, go to HOLD.
- HOLD: pkt_ready_out=0 (backpressure). Outputs stay stable while draw_valid_out=1 and draw_ready_in=0. When draw_ready_in=1: deassert draw_valid_out next cycle, go to HDR.

Latency: draw_valid_out rises exactly 1 cycle after the byte2 accept. Throughput: at most one point per 4 cycles.

Timeout (TIMEOUT_CYCLES > 0):
- An idle counter runs only in XLO and YB.
- It clears on every accepted byte and on every state entry.
- When it reaches TIMEOUT_CYCLES with no accept: discard the partial frame, pulse err_out with code 11, go to HDR.
- A byte accepted in the same cycle as the timeout is honoured; the timeout does not fire that cycle.

Error reporting:
- err_out is high for exactly one cycle per rejection.
- err_code_out holds its value until the next rejection.
- err_count_out increments on each err_out pulse and saturates at 255.

Reset:
- Synchronous; takes effect on the cycle rst_in is sampled high, including mid-frame or in HOLD.
- Next state is HDR. The partial frame is lost; this is not counted as an error.
- Reset values:
  - pkt_ready_out=0 while rst_in is high, 1 after.
  - draw_valid_out=0, x_out=0, y_out=0, color_out=0.
  - err_out=0, err_code_out=00, err_count_out=0.
  - Idle counter=0.

Width and arithmetic rules:
- x is 9 bits unsigned; y is 8 bits unsigned.
- Range compares are unsigned at those widths.
- With Y_MAX=256 the y check never fails.

Test Plan:
- Bytes 0xA0,0x2C,0x64 back-to-back with draw_ready_in=1 -> one draw_valid_out pulse 1 cycle after byte 0x64; x_out=300, y_out=100, color_out=3'b010; err_count_out=0.
- Header 0x35, then 0x50,0x10,0x20 -> 0x35 rejected with err_out pulse and code 01; next frame decodes x=16, y=32, color=5; err_count_out=1.
- Frame 0x80,0x50,0x0A (x=336) -> no draw_valid_out, err code 10; a following 0x00,0x05,0xEF gives x=5, y=239.
- Valid frame with draw_ready_in=0 for 10 cycles -> draw_valid_out and outputs held; pkt_ready_out=0 throughout; the next header is accepted only after the handshake completes.
- TIMEOUT_CYCLES=8: header 0x00 then 8 idle cycles -> err code 11, state back to HDR; the next 3-byte frame decodes correctly; a byte arriving exactly on cycle 8 is accepted with no error.
- Reset asserted after byte1 of a frame, then bytes 0x64,0x00,0x00 -> 0x64 is treated as a header (code 01, err_count_out=1); no stale point emitted; all outputs at reset values during rst_in.

Source files
------------

// File: rtl/pkt_dec_if.sv
// Link-side byte stream plus canvas-side point handshake and error reporting for pkt_dec.
// The master side is the link/canvas environment, and the slave side is the decoder.
interface pkt_dec_if;
  logic [7:0] pkt_in;
  logic       pkt_valid_in;
  logic       pkt_ready_out;
  logic [8:0] x_out;
  logic [7:0] y_out;
  logic [2:0] color_out;
  logic       draw_valid_out;
  logic       draw_ready_in;
  logic       err_out;
  logic [1:0] err_code_out;
  logic [7:0] err_count_out;

  modport master (
    output pkt_in, pkt_valid_in, draw_ready_in,
    input  pkt_ready_out, x_out, y_out, color_out, draw_valid_out,
           err_out, err_code_out, err_count_out
  );

  modport slave (
    input  pkt_in, pkt_valid_in, draw_ready_in,
    output pkt_ready_out, x_out, y_out, color_out, draw_valid_out,
           err_out, err_code_out, err_count_out
  );
endinterface

// File: rtl/pkt_dec.sv
// Reassembles 3-byte draw frames into (x, y, color) points. draw_valid_out rises 1 cycle after the last byte.
// The input stalls (pkt_ready_out=0) while a point waits for draw_ready_in.
module pkt_dec #(
  parameter int X_MAX          = 320,
  parameter int Y_MAX          = 240,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic     clk_in,
  input  logic     rst_in,
  pkt_dec_if.slave bus
);

  typedef enum logic [1:0] {HDR, XLO, YB, HOLD} state_t;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] color;
  } point_t;

  localparam logic [1:0] ERR_HDR     = 2'b01;
  localparam logic [1:0] ERR_RANGE   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  // The idle count never exceeds TIMEOUT_CYCLES-1, because it fires on the step that would reach the limit.
  localparam int                IDLE_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit                TO_EN     = (TIMEOUT_CYCLES > 0);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [9:0]        X_LIM     = 10'(X_MAX);
  localparam logic [8:0]        Y_LIM     = 9'(Y_MAX);

  state_t              state_q, state_d;
  logic [8:0]          x_pend_q, x_pend_d;
  logic [2:0]          color_pend_q, color_pend_d;
  point_t              pt_q, pt_d;
  logic                draw_vld_q, draw_vld_d;
  logic                err_q, err_d;
  logic [1:0]          err_code_q, err_code_d;
  logic [7:0]          err_cnt_q, err_cnt_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;

  logic                acc;
  logic                in_frame;
  logic                timeout;
  logic                rej;
  logic [1:0]          rej_code;

  assign bus.pkt_ready_out  = ~rst_in & (state_q != HOLD);
  assign bus.x_out          = pt_q.x;
  assign bus.y_out          = pt_q.y;
  assign bus.color_out      = pt_q.color;
  assign bus.draw_valid_out = draw_vld_q;
  assign bus.err_out        = err_q;
  assign bus.err_code_out   = err_code_q;
  assign bus.err_count_out  = err_cnt_q;

  always_comb begin
    state_d      = state_q;
    x_pend_d     = x_pend_q;
    color_pend_d = color_pend_q;
    pt_d         = pt_q;
    draw_vld_d   = draw_vld_q;
    err_d        = 1'b0;
    err_code_d   = err_code_q;
    err_cnt_d    = err_cnt_q;
    idle_d       = '0;
    rej          = 1'b0;
    rej_code     = ERR_HDR;

    acc      = bus.pkt_valid_in & bus.pkt_ready_out;
    in_frame = (state_q == XLO) || (state_q == YB);
    // A byte landing on the expiry cycle wins over the timeout.
    timeout  = TO_EN && in_frame && !acc && (idle_q == IDLE_LAST);

    unique case (state_q)
      HDR: begin
        if (acc) begin
          if (bus.pkt_in[3:0] == 4'b0000) begin
            x_pend_d[8]  = bus.pkt_in[7];
            color_pend_d = bus.pkt_in[6:4];
            state_d      = XLO;
          end else begin
            rej      = 1'b1;
            rej_code = ERR_HDR;
          end
        end
      end
      XLO: begin
        if (acc) begin
          x_pend_d[7:0] = bus.pkt_in;
          state_d       = YB;
        end else if (timeout) begin
          rej      = 1'b1;
          rej_code = ERR_TIMEOUT;
          state_d  = HDR;
        end
      end
      YB: begin
        if (acc) begin
          if (({1'b0, x_pend_q} >= X_LIM) || ({1'b0, bus.pkt_in} >= Y_LIM)) begin
            rej      = 1'b1;
            rej_code = ERR_RANGE;
            state_d  = HDR;
          end else begin
            pt_d       = '{x: x_pend_q, y: bus.pkt_in, color: color_pend_q};
            draw_vld_d = 1'b1;
            state_d    = HOLD;
          end
        end else if (timeout) begin
          rej      = 1'b1;
          rej_code = ERR_TIMEOUT;
          state_d  = HDR;
        end
      end
      HOLD: begin
        if (bus.draw_ready_in) begin
          draw_vld_d = 1'b0;
          state_d    = HDR;
        end
      end
      default: state_d = HDR;
    endcase

    if (rej) begin
      err_d      = 1'b1;
      err_code_d = rej_code;
      if (err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end

    // Count only idle cycles spent waiting inside a frame. Any accept or state change restarts the count.
    if (TO_EN && in_frame && !acc && (state_d == state_q)) begin
      idle_d = idle_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= HDR;
      x_pend_q     <= '0;
      color_pend_q <= '0;
      pt_q         <= '0;
      draw_vld_q   <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= 2'b00;
      err_cnt_q    <= '0;
      idle_q       <= '0;
    end else begin
      state_q      <= state_d;
      x_pend_q     <= x_pend_d;
      color_pend_q <= color_pend_d;
      pt_q         <= pt_d;
      draw_vld_q   <= draw_vld_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      err_cnt_q    <= err_cnt_d;
      idle_q       <= idle_d;
    end
  end

endmodule

// File: tb/tb_pkt_dec.sv
// Directed bench for pkt_dec. Expected points and rejections are queued as bytes are driven and checked when they emerge.
module tb_pkt_dec;

  typedef struct {
    int x;
    int y;
    int c;
  } exp_pt_t;

  typedef struct {
    int code;
    int cnt;
  } exp_err_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   model_cnt = 0;

  exp_pt_t  pt_q[$];
  exp_err_t err_q[$];
  exp_pt_t  ep;
  exp_err_t ee;

  pkt_dec_if bus();

  pkt_dec #(.X_MAX(320), .Y_MAX(240), .TIMEOUT_CYCLES(8)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    bus.pkt_in       = b;
    bus.pkt_valid_in = 1'b1;
    @(negedge clk);
    while (!bus.pkt_ready_out && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_wait", 32'(n < 50), 1);
    @(posedge clk);
    #1;
    bus.pkt_valid_in = 1'b0;
  endtask

  task automatic push_pt(input int x, input int y, input int c);
    pt_q.push_back('{x: x, y: y, c: c});
  endtask

  task automatic push_err(input int code);
    model_cnt = (model_cnt >= 255) ? 255 : model_cnt + 1;
    err_q.push_back('{code: code, cnt: model_cnt});
  endtask

  // Scoreboard side: every point handshake and every err pulse must match a queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.draw_valid_out && bus.draw_ready_in) begin
        chk("pt_expected", 32'(pt_q.size() != 0), 1);
        if (pt_q.size() != 0) begin
          ep = pt_q.pop_front();
          chk("pt_x", 32'(bus.x_out), ep.x);
          chk("pt_y", 32'(bus.y_out), ep.y);
          chk("pt_color", 32'(bus.color_out), ep.c);
        end
      end
      if (bus.err_out) begin
        chk("err_expected", 32'(err_q.size() != 0), 1);
        if (err_q.size() != 0) begin
          ee = err_q.pop_front();
          chk("err_code", 32'(bus.err_code_out), ee.code);
          chk("err_count", 32'(bus.err_count_out), ee.cnt);
        end
      end
    end
  end

  initial begin
    bus.pkt_in        = 8'h00;
    bus.pkt_valid_in  = 1'b0;
    bus.draw_ready_in = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(bus.pkt_ready_out), 0);
    chk("rst_valid", 32'(bus.draw_valid_out), 0);
    chk("rst_x", 32'(bus.x_out), 0);
    chk("rst_err", 32'(bus.err_out), 0);
    chk("rst_count", 32'(bus.err_count_out), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(bus.pkt_ready_out), 1);
    step();

    push_pt(300, 100, 2);
    send(8'hA0);
    send(8'h2C);
    send(8'h64);
    @(negedge clk);
    chk("latency_vld", 32'(bus.draw_valid_out), 1);
    step();
    @(negedge clk);
    chk("vld_drop", 32'(bus.draw_valid_out), 0);
    chk("count_clean", 32'(bus.err_count_out), 0);
    step();

    push_err(1);
    send(8'h35);
    push_pt(16, 32, 5);
    send(8'h50);
    send(8'h10);
    send(8'h20);
    repeat (3) step();
    @(negedge clk);
    chk("code_hold_hdr", 32'(bus.err_code_out), 1);
    chk("count_one", 32'(bus.err_count_out), 1);
    step();

    push_err(2);
    send(8'h80);
    send(8'h50);
    send(8'h0A);
    push_pt(5, 239, 0);
    send(8'h00);
    send(8'h05);
    send(8'hEF);
    repeat (3) step();
    @(negedge clk);
    chk("code_hold_range", 32'(bus.err_code_out), 2);
    step();

    push_pt(319, 239, 0);
    send(8'h80);
    send(8'h3F);
    send(8'hEF);
    push_err(2);
    send(8'h80);
    send(8'h40);
    send(8'h00);
    push_err(2);
    send(8'h00);
    send(8'h00);
    send(8'hF0);
    repeat (2) step();

    bus.draw_ready_in = 1'b0;
    push_pt(7, 8, 7);
    send(8'h70);
    send(8'h07);
    send(8'h08);
    bus.pkt_in       = 8'h20;
    bus.pkt_valid_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_vld", 32'(bus.draw_valid_out), 1);
      chk("hold_x", 32'(bus.x_out), 7);
      chk("hold_y", 32'(bus.y_out), 8);
      chk("hold_color", 32'(bus.color_out), 7);
      chk("hold_ready", 32'(bus.pkt_ready_out), 0);
    end
    step();
    bus.draw_ready_in = 1'b1;
    push_pt(33, 34, 2);
    send(8'h20);
    send(8'h21);
    send(8'h22);
    repeat (2) step();

    push_err(3);
    send(8'h00);
    repeat (8) step();
    @(negedge clk);
    chk("timeout_code", 32'(bus.err_code_out), 3);
    chk("timeout_ready", 32'(bus.pkt_ready_out), 1);
    step();
    push_pt(17, 18, 4);
    send(8'h40);
    send(8'h11);
    send(8'h12);
    repeat (2) step();
    push_pt(42, 43, 1);
    send(8'h10);
    repeat (7) step();
    send(8'h2A);
    send(8'h2B);
    repeat (3) step();

    send(8'h00);
    send(8'h05);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready_comb", 32'(bus.pkt_ready_out), 0);
    step();
    @(negedge clk);
    model_cnt = 0;
    chk("midrst_vld", 32'(bus.draw_valid_out), 0);
    chk("midrst_x", 32'(bus.x_out), 0);
    chk("midrst_y", 32'(bus.y_out), 0);
    chk("midrst_color", 32'(bus.color_out), 0);
    chk("midrst_err", 32'(bus.err_out), 0);
    chk("midrst_code", 32'(bus.err_code_out), 0);
    chk("midrst_count", 32'(bus.err_count_out), 0);
    chk("midrst_ready", 32'(bus.pkt_ready_out), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    push_err(1);
    send(8'h64);
    send(8'h00);
    push_err(3);
    send(8'h00);
    repeat (9) step();
    @(negedge clk);
    chk("post_rst_count", 32'(bus.err_count_out), 2);
    step();

    for (int i = 0; i < 260; i++) begin
      push_err(1);
      send(8'h01);
    end
    repeat (2) step();
    @(negedge clk);
    chk("count_saturated", 32'(bus.err_count_out), 255);

    repeat (3) step();
    chk("pt_queue_empty", 32'(pt_q.size()), 0);
    chk("err_queue_empty", 32'(err_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
